// File: rtl/mp_modport_if.sv
// Request/response bus between the cores' arbiter (master) and the shared
// compute/storage block (slave).
interface mp_modport_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic                  req;
    logic                  gnt;
    logic [1:0]            core_id;
    logic [3:0]            opcode;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rvalid;
    logic [1:0]            core_id_out;

    modport master (
        output req, core_id, opcode, A, B, addr, we, read_en,
        input  gnt, data_out, rvalid, core_id_out
    );

    modport slave (
        input  req, core_id, opcode, A, B, addr, we, read_en,
        output gnt, data_out, rvalid, core_id_out
    );
endinterface

// File: rtl/mp_modport.sv
// Shared compute/storage block: 16-op ALU feeding a 2**ADDR_WIDTH byte memory,
// one transaction per cycle, responses registered and tagged with the core ID.
module mp_modport #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    mp_modport_if.slave   bus
);

    function automatic logic [DATA_WIDTH-1:0] alu_op(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (op)
            4'd0:  r = '0;
            4'd1:  r = a + b;
            4'd2:  r = a - b;
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  r = ~a;
            4'd7:  r = a << b[2:0];
            4'd8:  r = a >> b[2:0];
            4'd9:  r = a;
            4'd10: r = b;
            4'd11: r = a + DATA_WIDTH'(1);
            4'd12: r = a - DATA_WIDTH'(1);
            4'd13: r = a * b;
            4'd14: r = (a == b) ? DATA_WIDTH'(1) : '0;
            4'd15: r = (a > b) ? a : b;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Stage p0: accept, ALU and memory lookup (combinational)
    logic                  accept_p0;
    logic                  resp_p0;
    logic [DATA_WIDTH-1:0] alu_p0;
    logic [DATA_WIDTH-1:0] rd_p0;

    assign accept_p0 = bus.req && reset_n;
    assign bus.gnt   = accept_p0;

    always_comb begin
        alu_p0  = alu_op(bus.opcode, bus.A, bus.B);
        rd_p0   = mem[bus.addr];
        resp_p0 = bus.read_en || !bus.we;
    end

    // Memory has no reset: written bytes survive a reset pulse
    always_ff @(posedge clk) begin
        if (accept_p0 && bus.we)
            mem[bus.addr] <= alu_p0;
    end

    // Stage p1: registered response
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [1:0]            cid_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            cid_p1  <= '0;
        end else begin
            vld_p1 <= accept_p0 && resp_p0;
            if (accept_p0 && resp_p0) begin
                // Plain reads return the pre-write content; writes echo R
                data_p1 <= (bus.we || !bus.read_en) ? alu_p0 : rd_p0;
                cid_p1  <= bus.core_id;
            end
        end
    end

    assign bus.rvalid      = vld_p1;
    assign bus.data_out    = data_p1;
    assign bus.core_id_out = cid_p1;

endmodule

// File: tb/tb_mp_modport.sv
// Scoreboard bench for mp_modport: expected responses are queued at drive
// time with the cycle they must appear in, and checked by a negedge monitor.
module tb_mp_modport;
    localparam int AW = 11;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    mp_modport_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    mp_modport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [1:0]    cid;
        logic [DW-1:0] data;
        int            cyc;
    } resp_t;

    resp_t         sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && bus.rvalid === 1'b1) begin
            resp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid data_out=%h core_id_out=%0d required=no response", bus.data_out, bus.core_id_out);
            end else begin
                e = sb.pop_front();
                if (bus.data_out !== e.data || bus.core_id_out !== e.cid || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL response data=%h cid=%0d cyc=%0d required data=%h cid=%0d cyc=%0d",
                             bus.data_out, bus.core_id_out, cyc, e.data, e.cid, e.cyc);
                end
            end
            last_data = bus.data_out;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [1:0] cid, input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [AW-1:0] ad, input logic w,
                        input logic r, input logic [DW-1:0] exp_d);
        resp_t e;
        bus.req = 1'b1; bus.core_id = cid; bus.opcode = op; bus.A = a; bus.B = b;
        bus.addr = ad; bus.we = w; bus.read_en = r;
        #1;
        checks++;
        if (bus.gnt !== 1'b1) begin
            errors++;
            $display("FAIL gnt_on_req gnt=%b required=1", bus.gnt);
        end
        if (r || !w) begin
            e.cid = cid; e.data = exp_d; e.cyc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    // Idle with req low but read_en high: nothing may respond, outputs hold
    task automatic idle(input int n);
        bus.req = 1'b0; bus.we = 1'b0; bus.read_en = 1'b1; bus.A = 8'hAA; bus.addr = '0;
        repeat (n) @(posedge clk);
        #1;
        checks++;
        if (bus.gnt !== 1'b0) begin
            errors++;
            $display("FAIL gnt_idle gnt=%b required=0", bus.gnt);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_response pending=%0d required=0", sb.size());
            sb.delete();
        end
        checks++;
        if (bus.data_out !== last_data) begin
            errors++;
            $display("FAIL data_hold data_out=%h required=%h", bus.data_out, last_data);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.gnt !== 1'b0 || bus.rvalid !== 1'b0 || bus.data_out !== '0 || bus.core_id_out !== 2'd0) begin
            errors++;
            $display("FAIL %s gnt=%b rvalid=%b data_out=%h core_id_out=%0d required all 0",
                     tag, bus.gnt, bus.rvalid, bus.data_out, bus.core_id_out);
        end
    endtask

    task automatic test_reset();
        bus.req = 1'b0; bus.core_id = 2'd3; bus.opcode = 4'd9; bus.A = 8'h55; bus.B = 8'h00;
        bus.addr = 11'd20; bus.we = 1'b0; bus.read_en = 1'b1;
        #2 reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req = ~bus.req;
            #1 check_reset_outputs("reset_hold_a");
            @(negedge clk);
            check_reset_outputs("reset_hold_b");
            @(posedge clk); #1;
        end
        bus.req = 1'b0;
        reset_n = 1'b1;
        last_data = '0;
    endtask

    task automatic test_write_read();
        send(2'd1, 4'd1, 8'h12, 8'h34, 11'h7FF, 1'b1, 1'b0, 8'h00);
        send(2'd2, 4'd0, 8'h00, 8'h00, 11'h7FF, 1'b0, 1'b1, 8'h46);
        idle(2);
    endtask

    task automatic test_compute();
        logic [3:0] ops [12] = '{4'd1, 4'd2, 4'd13, 4'd7, 4'd14, 4'd15, 4'd6, 4'd8, 4'd12, 4'd0, 4'd3, 4'd11};
        logic [7:0] as  [12] = '{8'hFF, 8'h00, 8'd16, 8'h81, 8'h5A, 8'h80, 8'h0F, 8'h81, 8'h00, 8'h77, 8'hF0, 8'hFF};
        logic [7:0] bs  [12] = '{8'h02, 8'h01, 8'd16, 8'h09, 8'h5A, 8'h7F, 8'h00, 8'h09, 8'h00, 8'h33, 8'h3C, 8'h00};
        logic [7:0] rs  [12] = '{8'h01, 8'hFF, 8'h00, 8'h02, 8'h01, 8'h80, 8'hF0, 8'h40, 8'hFF, 8'h00, 8'h30, 8'h00};
        for (int i = 0; i < 12; i++)
            send(2'(i), ops[i], as[i], bs[i], 11'(i), 1'b0, 1'b0, rs[i]);
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            send(2'd0, 4'd10, 8'h00, 8'(8'hA0 + i), 11'(100 + i), 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++)
            send(2'(i), 4'd0, 8'h00, 8'h00, 11'(100 + i), 1'b0, 1'b1, 8'(8'hA0 + i));
        idle(2);
    endtask

    task automatic test_write_through_reset();
        send(2'd3, 4'd9, 8'hC3, 8'h00, 11'd5, 1'b1, 1'b1, 8'hC3);
        idle(1);
        // Reset mid-stream with a pending write to addr 5: it must be dropped
        bus.req = 1'b1; bus.we = 1'b1; bus.read_en = 1'b1; bus.opcode = 4'd9;
        bus.A = 8'h11; bus.addr = 11'd5; bus.core_id = 2'd1;
        reset_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(posedge clk); #1;
        check_reset_outputs("reset_pulse");
        bus.req = 1'b0;
        reset_n = 1'b1;
        last_data = '0;
        send(2'd1, 4'd0, 8'h00, 8'h00, 11'd5, 1'b0, 1'b1, 8'hC3);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_compute();
        test_back_to_back();
        test_write_through_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
